// File: rtl/sd_beat_packer_pkg.sv
// Shared constants, beat record and strobe helper for the SD DMA beat packer.
package sd_dma_pkg;

   localparam int DATA_WIDTH = 256;
   localparam int IN_WIDTH   = 16;
   localparam int FIFO_DEPTH = 4;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int LANES      = DATA_WIDTH / IN_WIDTH;
   localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int DEPTH_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = DEPTH_W + 1;

   // One buffered output beat: data, byte strobes and transfer-end flag.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [STRB_WIDTH-1:0] strb;
      logic                  last;
   } beat_t;

   // Strobe mask covering the two byte lanes of 16-bit word lane idx.
   function automatic logic [STRB_WIDTH-1:0] lane_strb(input int unsigned idx);
      logic [STRB_WIDTH-1:0] m;
      m      = '0;
      m[1:0] = 2'b11;
      return m << (2 * idx);
   endfunction

endpackage

// File: rtl/sd_beat_packer_if.sv
// Word-in / beat-out handshake bundle of the beat packer.
interface sd_beat_packer_if #(
   parameter int DATA_WIDTH = 256,
   parameter int IN_WIDTH   = 16
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  in_en;
   logic [IN_WIDTH-1:0]   in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [STRB_WIDTH-1:0] out_strb;
   logic                  out_last;

   // Packer side: consumes words, produces beats.
   modport slave (
      input  in_en, in_data, in_last, out_ready,
      output out_valid, out_data, out_strb, out_last
   );

   // Environment side: produces words, consumes beats.
   modport master (
      output in_en, in_data, in_last, out_ready,
      input  out_valid, out_data, out_strb, out_last
   );
endinterface

// File: rtl/sd_beat_packer_fifo.sv
// Small synchronous first-word-fall-through FIFO holding packed beats.
module sd_beat_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_empty;
   logic             w_do_pop;
   logic             w_do_push;

   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !w_empty;
   // A push into a full FIFO only lands when the head leaves in the same cycle.
   assign w_do_push = i_push && (!w_full || w_do_pop);

   // Storage write; contents need no reset because the head is masked while empty.
   always_ff @(posedge i_clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push)
            r_count <= r_count - 1'b1;
      end
   end

   assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_empty = w_empty;
   assign o_count = r_count;
endmodule

// File: rtl/sd_beat_packer.sv
// Packs 16-bit SD words into wide beats and queues them for the AXI writer.
module sd_beat_packer
   import sd_dma_pkg::*;
(
   input  logic             sys_clk,
   input  logic             rst,
   sd_beat_packer_if.slave  bus,
   output logic             overflow,
   output logic [15:0]      beat_count
);
   logic [LANE_W-1:0]     r_idx;
   logic [DATA_WIDTH-1:0] r_asm_data;
   logic [STRB_WIDTH-1:0] r_asm_strb;
   logic                  r_overflow;
   logic [15:0]           r_beat_count;

   logic [DATA_WIDTH-1:0] w_merge_data;
   logic [STRB_WIDTH-1:0] w_merge_strb;
   logic                  w_close;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_drop;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_fifo_count;
   beat_t                 w_wbeat;
   beat_t                 w_rbeat;

   // Overlay the incoming word onto its lane so the closing word joins the beat it ends.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign w_merge_data[gi*IN_WIDTH +: IN_WIDTH] =
            (bus.in_en && (r_idx == LANE_W'(gi))) ? bus.in_data
                                                   : r_asm_data[gi*IN_WIDTH +: IN_WIDTH];
      end
   endgenerate

   assign w_merge_strb = bus.in_en ? (r_asm_strb | lane_strb(32'(r_idx))) : r_asm_strb;
   assign w_close      = bus.in_en && ((r_idx == LANE_W'(LANES-1)) || bus.in_last);
   assign w_pop        = bus.out_valid && bus.out_ready;
   assign w_full       = (w_fifo_count == CNT_W'(FIFO_DEPTH));
   assign w_drop       = w_close && w_full && !w_pop;

   assign w_wbeat.data = w_merge_data;
   assign w_wbeat.strb = w_merge_strb;
   assign w_wbeat.last = bus.in_last;

   // Lane assembly: accumulate words, restart from lane 0 once a beat closes.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_idx      <= '0;
         r_asm_data <= '0;
         r_asm_strb <= '0;
      end else if (bus.in_en) begin
         if (w_close) begin
            r_idx      <= '0;
            r_asm_data <= '0;
            r_asm_strb <= '0;
         end else begin
            r_idx      <= r_idx + 1'b1;
            r_asm_data <= w_merge_data;
            r_asm_strb <= w_merge_strb;
         end
      end
   end

   // Sticky drop flag and accepted-beat counter; the input side cannot be stalled.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_beat_count <= '0;
      end else begin
         if (w_drop)
            r_overflow <= 1'b1;
         if (w_close && !w_drop)
            r_beat_count <= r_beat_count + 16'd1;
      end
   end

   sd_beat_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (sys_clk),
      .i_rst   (rst),
      .i_push  (w_close),
      .i_wdata (w_wbeat),
      .i_pop   (w_pop),
      .o_rdata (w_rbeat),
      .o_empty (w_empty),
      .o_count (w_fifo_count)
   );

   assign bus.out_valid = !w_empty;
   assign bus.out_data  = w_rbeat.data;
   assign bus.out_strb  = w_rbeat.strb;
   assign bus.out_last  = w_rbeat.last;
   assign overflow      = r_overflow;
   assign beat_count    = r_beat_count;
endmodule

// File: tb/tb_sd_beat_packer.sv
// Scoreboard bench for sd_beat_packer: directed word streams, monitor-side beat checks.
module tb_sd_beat_packer;
   import sd_dma_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        overflow;
   logic [15:0] beat_count;

   sd_beat_packer_if #(.DATA_WIDTH(DATA_WIDTH), .IN_WIDTH(IN_WIDTH)) bus ();

   sd_beat_packer dut (
      .sys_clk    (clk),
      .rst        (rst),
      .bus        (bus),
      .overflow   (overflow),
      .beat_count (beat_count)
   );

   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   int    n_beats  = 0;

   task automatic check(input string name, input logic [DATA_WIDTH-1:0] act,
                        input logic [DATA_WIDTH-1:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   // Monitor: every accepted beat is compared against the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            n_beats++;
            $display("beat %0d: strb=%h last=%0d data[63:0]=%h", n_beats,
                     bus.out_strb, bus.out_last, bus.out_data[63:0]);
            check("beat_data", bus.out_data, e.data);
            check("beat_strb", DATA_WIDTH'(bus.out_strb), DATA_WIDTH'(e.strb));
            check("beat_last", DATA_WIDTH'(bus.out_last), DATA_WIDTH'(e.last));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_WIDTH-1:0] full_beat(input logic [15:0] base);
      logic [DATA_WIDTH-1:0] d;
      for (int i = 0; i < LANES; i++)
         d[i*IN_WIDTH +: IN_WIDTH] = base + 16'(i);
      return d;
   endfunction

   task automatic push_exp(input logic [DATA_WIDTH-1:0] d, input logic [STRB_WIDTH-1:0] s,
                           input logic l);
      beat_t b;
      b.data = d;
      b.strb = s;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic send_word(input logic [15:0] w, input logic last);
      bus.in_en   = 1'b1;
      bus.in_data = w;
      bus.in_last = last;
      @(posedge clk);
      #1;
      bus.in_en   = 1'b0;
      bus.in_data = '0;
      bus.in_last = 1'b0;
   endtask

   task automatic send_beat(input logic [15:0] base, input logic last);
      for (int i = 0; i < LANES; i++)
         send_word(base + 16'(i), last && (i == LANES-1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain();
      int k;
      k = 0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && k < 500) begin
         @(posedge clk);
         k++;
      end
      @(posedge clk);
      #1;
      check("drain_left", DATA_WIDTH'(exp_q.size()), 0);
      check("drain_valid", DATA_WIDTH'(bus.out_valid), 0);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_en     = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();
      check("rst_valid", DATA_WIDTH'(bus.out_valid), 0);
      check("rst_data", bus.out_data, 0);
      check("rst_strb", DATA_WIDTH'(bus.out_strb), 0);
      check("rst_last", DATA_WIDTH'(bus.out_last), 0);
      check("rst_overflow", DATA_WIDTH'(overflow), 0);
      check("rst_beat_count", DATA_WIDTH'(beat_count), 0);

      // Single full beat 0x0001..0x0010 ending the transfer.
      bus.out_ready = 1'b1;
      push_exp(full_beat(16'h0001), 32'hFFFF_FFFF, 1'b1);
      for (int i = 1; i <= 15; i++)
         send_word(16'(i), 1'b0);
      check("t1_valid_before_close", DATA_WIDTH'(bus.out_valid), 0);
      send_word(16'h0010, 1'b1);
      check("t1_valid_latency", DATA_WIDTH'(bus.out_valid), 1);
      drain();
      check("t1_beat_count", DATA_WIDTH'(beat_count), 1);

      // One 512-byte sector: 256 words, 16 beats, last only on the final one.
      do_reset();
      for (int b = 0; b < 16; b++)
         push_exp(full_beat(16'(b*16)), 32'hFFFF_FFFF, b == 15);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 256; k++)
         send_word(16'(k), k == 255);
      drain();
      check("t2_overflow", DATA_WIDTH'(overflow), 0);
      check("t2_beat_count", DATA_WIDTH'(beat_count), 16);

      // Partial beat of three words.
      do_reset();
      push_exp(DATA_WIDTH'(48'hCCCC_BBBB_AAAA), 32'h0000_003F, 1'b1);
      bus.out_ready = 1'b1;
      send_word(16'hAAAA, 1'b0);
      send_word(16'hBBBB, 1'b0);
      send_word(16'hCCCC, 1'b1);
      drain();
      check("t3_beat_count", DATA_WIDTH'(beat_count), 1);

      // Five beats into a stalled depth-4 FIFO: fifth dropped, first four intact.
      do_reset();
      bus.out_ready = 1'b0;
      for (int b = 0; b < 4; b++)
         push_exp(full_beat(16'h1000 + 16'(b*16)), 32'hFFFF_FFFF, 1'b0);
      for (int b = 0; b < 4; b++)
         send_beat(16'h1000 + 16'(b*16), 1'b0);
      check("t4_overflow_at_full", DATA_WIDTH'(overflow), 0);
      check("t4_count_at_full", DATA_WIDTH'(beat_count), 4);
      send_beat(16'h1040, 1'b0);
      check("t4_overflow_set", DATA_WIDTH'(overflow), 1);
      check("t4_count_no_inc", DATA_WIDTH'(beat_count), 4);
      check("t4_head_held", bus.out_data, full_beat(16'h1000));
      drain();
      check("t4_overflow_sticky", DATA_WIDTH'(overflow), 1);

      // Full FIFO, closing word coincides with a pop: accepted, no overflow.
      do_reset();
      bus.out_ready = 1'b0;
      for (int b = 0; b < 5; b++)
         push_exp(full_beat(16'h2000 + 16'(b*16)), 32'hFFFF_FFFF, 1'b0);
      for (int b = 0; b < 4; b++)
         send_beat(16'h2000 + 16'(b*16), 1'b0);
      for (int i = 0; i < LANES-1; i++)
         send_word(16'h2040 + 16'(i), 1'b0);
      bus.out_ready = 1'b1;
      send_word(16'h204F, 1'b0);
      bus.out_ready = 1'b0;
      check("t5_overflow", DATA_WIDTH'(overflow), 0);
      check("t5_fifo_count", DATA_WIDTH'(dut.u_fifo.r_count), 4);
      check("t5_beat_count", DATA_WIDTH'(beat_count), 5);
      drain();

      // Reset in the middle of a beat discards the partial words.
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 7; i++)
         send_word(16'h0F00 + 16'(i), 1'b0);
      do_reset();
      check("t6_valid", DATA_WIDTH'(bus.out_valid), 0);
      check("t6_overflow", DATA_WIDTH'(overflow), 0);
      check("t6_beat_count", DATA_WIDTH'(beat_count), 0);
      push_exp(full_beat(16'h0100), 32'hFFFF_FFFF, 1'b1);
      bus.out_ready = 1'b1;
      send_beat(16'h0100, 1'b1);
      drain();
      check("t6_beat_count_after", DATA_WIDTH'(beat_count), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
